pixel_stream_reader_nch: RTL and testbench

//  Synthesizable, parametrised successor to the file-driven 3-channel image generator.

---
 rtl/pixel_stream_reader_nch_pkg.sv | 31 +++
 rtl/pixel_stream_reader_nch_if.sv | 22 ++
 rtl/pixel_stream_reader_nch_skid.sv | 32 +++
 rtl/pixel_stream_reader_nch.sv | 185 ++++++++++++++++++
 tb/tb_pixel_stream_reader_nch.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_reader_nch_pkg.sv
// Shared types and sizing helpers for pixel_stream_reader_nch.
// ZERO_PAD_EN selects the padded-frame dimensions used by the reader.
package pixel_stream_reader_nch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

`ifdef ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  function automatic int pixW(input int numCh, input int dWidth);
    return numCh * dWidth;
  endfunction

  // A zero border adds one pixel on each side of the stored frame.
  function automatic int frameDim(input int d);
    return d + 2 * PAD;
  endfunction

  function automatic int cntW(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_stream_reader_nch_if.sv
// Memory read port and downstream FIFO write port of the pixel stream reader.
interface pixel_stream_reader_nch_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int PIX_W      = 256
);
  logic                  mem_rden;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [PIX_W-1:0]      mem_rdata;
  logic                  fifo_full;
  logic                  fifo_wrreq;
  logic [PIX_W-1:0]      fifo_data;

  modport master (
    output mem_rden, mem_addr, fifo_wrreq, fifo_data,
    input  mem_rdata, fifo_full
  );

  modport slave (
    input  mem_rden, mem_addr, fifo_wrreq, fifo_data,
    output mem_rdata, fifo_full
  );
endinterface

// File: rtl/pixel_stream_reader_nch_skid.sv
// One-entry skid buffer catching a memory return word that arrives while the FIFO is full.
module stream_skid_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pixel_stream_reader_nch.sv
// Streams NUM_PASS x NUM_IMG raster images from packed memory into a full-aware FIFO.
// Define ZERO_PAD_EN to wrap every image in a one-pixel all-zero border.
module pixel_stream_reader_nch
  import pixel_stream_reader_nch_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int NUM_CH     = 8,
  parameter int WIDTH      = 224,
  parameter int HEIGHT     = 224,
  parameter int NUM_IMG    = 1,
  parameter int NUM_PASS   = 1,
  parameter int ADDR_WIDTH = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  pixel_stream_reader_nch_if.master bus
);

  localparam int PIX_W   = pixW(NUM_CH, DWIDTH);
  localparam int FRAME_W = frameDim(WIDTH);
  localparam int FRAME_H = frameDim(HEIGHT);
  localparam int XW      = cntW(FRAME_W);
  localparam int YW      = cntW(FRAME_H);
  localparam int IW      = cntW(NUM_IMG);
  localparam int PW      = cntW(NUM_PASS);

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_IMG - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PASS - 1);

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [IW-1:0]         img_q, img_d;
  logic [PW-1:0]         pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inFlight_q;
  logic [PIX_W-1:0]      lastData_q;

  logic             issue;
  logic             passEnd;
  logic             lastIssue;
  logic             interior;
  logic [PIX_W-1:0] retWord;
  logic             skidValid;
  logic [PIX_W-1:0] skidData;
  logic             wrReq;
  logic [PIX_W-1:0] wrData;

`ifdef ZERO_PAD_EN
  logic padTag_q;

  assign interior = (x_q != '0) && (x_q != X_LAST) && (y_q != '0) && (y_q != Y_LAST);
  assign retWord  = padTag_q ? '0 : bus.mem_rdata;

  // Border pixels travel through the return pipeline as a tag instead of a memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) padTag_q <= 1'b0;
    else       padTag_q <= ~interior;
  end
`else
  assign interior = 1'b1;
  assign retWord  = bus.mem_rdata;
`endif

  // Issue is held off while the skid is occupied, so a return never meets a full skid.
  assign issue     = (state_q == RUN) && !bus.fifo_full && !skidValid;
  assign passEnd   = (x_q == X_LAST) && (y_q == Y_LAST) && (img_q == I_LAST);
  assign lastIssue = issue && passEnd && (pass_q == P_LAST);

  assign bus.mem_rden = issue && interior;
  assign bus.mem_addr = addr_q;

  stream_skid_reg #(.DATA_W(PIX_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inFlight_q && bus.fifo_full),
    .in_data   (retWord),
    .out_ready (!bus.fifo_full),
    .out_valid (skidValid),
    .out_data  (skidData)
  );

  always_comb begin
    wrReq  = 1'b0;
    wrData = lastData_q;
    if (inFlight_q && !bus.fifo_full) begin
      wrReq  = 1'b1;
      wrData = retWord;
    end else if (skidValid && !bus.fifo_full) begin
      wrReq  = 1'b1;
      wrData = skidData;
    end
  end

  assign bus.fifo_wrreq = wrReq;
  assign bus.fifo_data  = wrData;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    img_d  = img_q;
    pass_d = pass_q;
    addr_d = addr_q;
    if (state_q == IDLE && start) begin
      x_d    = '0;
      y_d    = '0;
      img_d  = '0;
      pass_d = '0;
      addr_d = '0;
    end else if (issue) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
          if (img_q == I_LAST) begin
            img_d  = '0;
            pass_d = (pass_q == P_LAST) ? '0 : pass_q + PW'(1);
          end else begin
            img_d = img_q + IW'(1);
          end
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
      // Images sit back to back, so the address is a plain running count within a pass.
      if (passEnd)       addr_d = '0;
      else if (interior) addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastIssue) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once nothing will still be pending after this cycle's write.
        if (!((inFlight_q || skidValid) && bus.fifo_full)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      img_q      <= '0;
      pass_q     <= '0;
      addr_q     <= '0;
      inFlight_q <= 1'b0;
      lastData_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      img_q      <= img_d;
      pass_q     <= pass_d;
      addr_q     <= addr_d;
      inFlight_q <= issue;
      lastData_q <= wrData;
    end
  end

endmodule

// File: tb/tb_pixel_stream_reader_nch.sv
// Directed bench for pixel_stream_reader_nch; build with ZERO_PAD_EN to exercise the padded frame.
module tb_pixel_stream_reader_nch;

  localparam int PIX_W = 96;
  localparam int AW    = 8;
`ifdef ZERO_PAD_EN
  localparam int A_W = 2;
  localparam int A_H = 2;
`else
  localparam int A_W = 4;
  localparam int A_H = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic startA, startB, fullA, fullB;
  logic busyA, doneA, busyB, doneB;

  int checkCount = 0;
  int errorCount = 0;
  int cycCnt     = 0;

  logic [PIX_W-1:0] wrDataA[$];
  int               wrCycA[$];
  logic [PIX_W-1:0] wrDataB[$];
  logic [AW-1:0]    addrQB[$];
  int rdenCntA, doneCntA, doneCycA, rdenCntB, doneCntB;
  logic busyAtDoneA;

  pixel_stream_reader_nch_if #(.ADDR_WIDTH(AW), .PIX_W(PIX_W)) busA();
  pixel_stream_reader_nch_if #(.ADDR_WIDTH(AW), .PIX_W(PIX_W)) busB();

  pixel_stream_reader_nch #(
    .DWIDTH(32), .NUM_CH(3), .WIDTH(A_W), .HEIGHT(A_H),
    .NUM_IMG(1), .NUM_PASS(1), .ADDR_WIDTH(AW)
  ) dutA (
    .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA), .bus(busA)
  );

  pixel_stream_reader_nch #(
    .DWIDTH(32), .NUM_CH(3), .WIDTH(4), .HEIGHT(2),
    .NUM_IMG(2), .NUM_PASS(2), .ADDR_WIDTH(AW)
  ) dutB (
    .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB), .bus(busB)
  );

  always #5 clk = ~clk;

  assign busA.fifo_full = fullA;
  assign busB.fifo_full = fullB;

  always @(posedge clk) begin
    cycCnt <= cycCnt + 1;
    if (busA.mem_rden) busA.mem_rdata <= {3{32'(busA.mem_addr)}};
    if (busB.mem_rden) busB.mem_rdata <= {3{32'(busB.mem_addr)}};
  end

  always @(negedge clk) begin
    if (busA.fifo_wrreq) begin
      wrDataA.push_back(busA.fifo_data);
      wrCycA.push_back(cycCnt);
      checkOutput("noWriteWhileFullA", 96'(busA.fifo_full), 96'(0));
    end
    if (busA.mem_rden) rdenCntA++;
    if (doneA) begin
      doneCntA++;
      doneCycA    = cycCnt;
      busyAtDoneA = busyA;
    end
    if (busB.fifo_wrreq) begin
      wrDataB.push_back(busB.fifo_data);
      checkOutput("noWriteWhileFullB", 96'(busB.fifo_full), 96'(0));
    end
    if (busB.mem_rden) begin
      rdenCntB++;
      addrQB.push_back(busB.mem_addr);
    end
    if (doneB) doneCntB++;
  end

  task automatic checkOutput(input string tag, input logic [PIX_W-1:0] actual,
                             input logic [PIX_W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit useB);
    if (useB) startB = 1'b1;
    else      startA = 1'b1;
    nextCycle();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic clearLogs();
    wrDataA.delete();
    wrCycA.delete();
    wrDataB.delete();
    addrQB.delete();
    rdenCntA = 0;
    doneCntA = 0;
    doneCycA = -1;
    rdenCntB = 0;
    doneCntB = 0;
  endtask

  task automatic waitDone(input bit useB, input int budget);
    int n = 0;
    while (((useB ? doneCntB : doneCntA) == 0) && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput(useB ? "doneSeenB" : "doneSeenA",
                96'((useB ? doneCntB : doneCntA) != 0), 96'(1));
  endtask

  task automatic waitWritesA(input int count, input int budget);
    int n = 0;
    while (wrDataA.size() < count && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("writesReachedA", 96'(wrDataA.size() >= count), 96'(1));
  endtask

  task automatic checkSeqA(input string tag, input int n);
    checkOutput({tag, "Count"}, 96'(wrDataA.size()), 96'(n));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%sData%0d", tag, i),
                  (i < wrDataA.size()) ? wrDataA[i] : '1, {3{32'(i)}});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Rden"},  96'(busA.mem_rden),   96'(0));
    checkOutput({tag, "Addr"},  96'(busA.mem_addr),   96'(0));
    checkOutput({tag, "Wrreq"}, 96'(busA.fifo_wrreq), 96'(0));
    checkOutput({tag, "Data"},  busA.fifo_data,       96'(0));
    checkOutput({tag, "Busy"},  96'(busyA),           96'(0));
    checkOutput({tag, "Done"},  96'(doneA),           96'(0));
  endtask

`ifdef ZERO_PAD_EN
  int padExp[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 3, 0, 0, 0, 0, 0};
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    int r0;
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    fullA  = 1'b0;
    fullB  = 1'b0;
    clearLogs();
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkResetOutputs("reset");
    nextCycle();
    reset = 1'b0;
    nextCycle();

`ifdef ZERO_PAD_EN
    $display("[TB] padded 2x2 frame");
    clearLogs();
    applyStimulus(1'b0);
    waitDone(1'b0, 200);
    checkOutput("padCount", 96'(wrDataA.size()), 96'(16));
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("padData%0d", i),
                  (i < wrDataA.size()) ? wrDataA[i] : '1, {3{32'(padExp[i])}});
    checkOutput("padRdenCount", 96'(rdenCntA), 96'(4));
    checkOutput("padDoneCount", 96'(doneCntA), 96'(1));
`else
    $display("[TB] test1 free-running stream");
    clearLogs();
    sc = cycCnt;
    applyStimulus(1'b0);
    checkOutput("t1BusyAfterStart", 96'(busyA), 96'(1));
    waitDone(1'b0, 100);
    checkSeqA("t1", 8);
    checkOutput("t1FirstWriteCycle", 96'(wrCycA.size() > 0 ? wrCycA[0] : -1), 96'(sc + 2));
    checkOutput("t1DoneCycle", 96'(doneCycA), 96'(sc + 10));
    checkOutput("t1BusyAtDone", 96'(busyAtDoneA), 96'(0));
    nextCycle();
    nextCycle();
    checkOutput("t1DoneCount", 96'(doneCntA), 96'(1));

    $display("[TB] test2 toggling fifo_full");
    clearLogs();
    fullA  = 1'($urandom_range(0, 1));
    startA = 1'b1;
    for (int i = 0; i < 300 && doneCntA == 0; i++) begin
      nextCycle();
      startA = 1'b0;
      fullA  = ~fullA;
    end
    fullA = 1'b0;
    checkOutput("t2DoneSeen", 96'(doneCntA), 96'(1));
    checkSeqA("t2", 8);

    $display("[TB] test3 ten-cycle stall");
    clearLogs();
    applyStimulus(1'b0);
    waitWritesA(4, 50);
    fullA = 1'b1;
    r0    = rdenCntA;
    repeat (10) nextCycle();
    fullA = 1'b0;
    checkOutput("t3ExtraReadsAtMostOne", 96'((rdenCntA - r0) <= 1), 96'(1));
    checkOutput("t3NoWriteWhileStalled", 96'(wrDataA.size()), 96'(4));
    @(negedge clk);
    checkOutput("t3ResumeWrreq", 96'(busA.fifo_wrreq), 96'(1));
    checkOutput("t3ResumeData", busA.fifo_data, {3{32'd4}});
    waitDone(1'b0, 100);
    checkSeqA("t3", 8);

    $display("[TB] test4 two images, two passes");
    clearLogs();
    applyStimulus(1'b1);
    checkOutput("t4BusyB", 96'(busyB), 96'(1));
    repeat (3) nextCycle();
    applyStimulus(1'b1);
    waitDone(1'b1, 200);
    repeat (5) nextCycle();
    checkOutput("t4WriteCount", 96'(wrDataB.size()), 96'(32));
    checkOutput("t4ReadCount", 96'(rdenCntB), 96'(32));
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("t4Data%0d", i),
                  (i < wrDataB.size()) ? wrDataB[i] : '1, {3{32'(i % 16)}});
      checkOutput($sformatf("t4Addr%0d", i),
                  96'((i < addrQB.size()) ? addrQB[i] : 8'hFF), 96'(i % 16));
    end
    checkOutput("t4DoneCount", 96'(doneCntB), 96'(1));

    $display("[TB] test5 reset mid-stream");
    clearLogs();
    applyStimulus(1'b0);
    waitWritesA(6, 50);
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("t5Reset");
    nextCycle();
    reset = 1'b0;
    repeat (5) nextCycle();
    checkOutput("t5NoDone", 96'(doneCntA), 96'(0));
    checkOutput("t5IdleBusy", 96'(busyA), 96'(0));
    checkOutput("t5IdleRden", 96'(busA.mem_rden), 96'(0));
    clearLogs();
    applyStimulus(1'b0);
    waitDone(1'b0, 100);
    checkSeqA("t5Replay", 8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
